// File: rtl/cosh_series_ctrl_pkg.sv
// cosh_series_ctrl_pkg: shared state encoding and fixed-point constants for the cosh series controller.
package cosh_pkg;
    typedef enum logic [2:0] {IDLE, SQUARE, MUL_X, MUL_C, DONE} state_t;
    localparam int FRAC_BITS = 8;
    localparam logic [9:0] ONE_2P8 = 10'h100;
    localparam int LUT_DEPTH = 8;
endpackage

// File: rtl/cosh_series_ctrl_if.sv
// cosh_series_ctrl_if: requester handshake plus the external coefficient LUT port.
interface cosh_series_ctrl_if;
    logic       start;
    logic [7:0] x;
    logic       ready;
    logic       done;
    logic [9:0] result;
    logic [2:0] lut_adr;
    logic [7:0] lut_data;
    modport master(output start, x, lut_data, input ready, done, result, lut_adr);
    modport slave(input start, x, lut_data, output ready, done, result, lut_adr);
endinterface

// File: rtl/cosh_series_ctrl.sv
// cosh_series_ctrl: iterative 2.8 fixed-point cosh(x) via x^2 and LUT coefficients on one shared term.
module cosh_series_ctrl
    import cosh_pkg::*;
#(
    parameter int N_TERMS = LUT_DEPTH
) (
    input logic              clk,
    input logic              rst,
    cosh_series_ctrl_if.slave bus
);
    localparam logic [2:0] LAST_K = 3'(N_TERMS - 1);
    state_t     r_state;
    logic [7:0] r_x;
    logic [7:0] r_x2;
    logic [8:0] r_term;
    logic [9:0] r_acc;
    logic [2:0] r_k;
    logic       r_ready;
    logic       r_done;
    logic [9:0] r_result;
    logic [7:0] w_x2;
    logic [8:0] w_tx;
    logic [8:0] w_t;
    logic [9:0] w_sum;
    assign w_x2  = 8'((16'(r_x) * 16'(r_x)) >> FRAC_BITS);
    assign w_tx  = 9'((17'(r_term) * 17'(r_x2)) >> FRAC_BITS);
    assign w_t   = 9'((17'(r_term) * 17'(bus.lut_data)) >> FRAC_BITS);
    assign w_sum = r_acc + 10'(w_t);
    assign bus.ready   = r_ready;
    assign bus.done    = r_done;
    assign bus.result  = r_result;
    assign bus.lut_adr = r_k;
    // Final sum is latched together with done so the result is valid in the done cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_x      <= '0;
            r_x2     <= '0;
            r_term   <= '0;
            r_acc    <= '0;
            r_k      <= '0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (bus.start) begin
                    r_x     <= bus.x;
                    r_term  <= 9'h100;
                    r_acc   <= ONE_2P8;
                    r_k     <= '0;
                    r_ready <= 1'b0;
                    r_state <= SQUARE;
                end
                SQUARE: begin
                    r_x2    <= w_x2;
                    r_state <= MUL_X;
                end
                MUL_X: begin
                    r_term  <= w_tx;
                    r_state <= MUL_C;
                end
                MUL_C: begin
                    r_term <= w_t;
                    r_acc  <= w_sum;
                    if (r_k == LAST_K) begin
                        r_result <= w_sum;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end else begin
                        r_k     <= r_k + 3'd1;
                        r_state <= MUL_X;
                    end
                end
                DONE: begin
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
